param_fetch_ctrl: RTL and testbench

- Sequences per-layer loading of GAT parameters from the single shared parameter BRAM read port.
- Weight matrix W is fetched first and scattered column-wise into W_NUM_OF_COLS bank write ports. The attention vector a is fetched next into an indexed register write port.
- Sits between the host-loaded parameter BRAM and the W/a consumer storage. Raises w_rdy_o and a_rdy_o for the downstream multipliers and attention logic.

---
 rtl/gat_pkg.sv | 29 ++
 rtl/param_rd_pipe.sv | 43 ++++
 rtl/param_fetch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_param_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT parameter fetch path.
// Tag fields are sized for the largest supported W/a geometry.
package gat_pkg;

    localparam int TAG_FW       = 8;
    localparam int NW           = 16 * 16;
    localparam int PARAM_ADDR_W = $clog2(NW + 32);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_W,
        FETCH_A,
        DRAIN,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic              valid;
        logic              is_a;
        logic [TAG_FW-1:0] col;
        logic [TAG_FW-1:0] row_idx;
    } fetch_tag_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_rd_pipe.sv
// Tag shift register that tracks BRAM reads in flight.
// empty_o: nothing left once the current output tag retires.
module param_rd_pipe
    import gat_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       clr_i,
    input  fetch_tag_t tag_i,
    output fetch_tag_t tag_o,
    output logic       empty_o
);

    fetch_tag_t stage_q [LAT];

    // Shift tags one stage per cycle; clear drops all in-flight reads.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[LAT-1];

    // Look only at stages behind the output one.
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (stage_q[i].valid) begin
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_fetch_ctrl.sv
// Loads W (column-scattered) then a from the shared param BRAM.
// Write ports are driven straight from the retiring read tag.
module param_fetch_ctrl
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int W_NUM_OF_ROWS = 16,
    parameter int W_NUM_OF_COLS = 16,
    parameter int A_DEPTH       = 32,
    parameter int BRAM_LAT      = 2,
    parameter int PARAM_ADDR_W  =
        clog2w(W_NUM_OF_ROWS * W_NUM_OF_COLS + A_DEPTH),
    localparam int ROW_W = clog2w(W_NUM_OF_ROWS),
    localparam int COL_W = clog2w(W_NUM_OF_COLS),
    localparam int IDX_W = clog2w(A_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     stall_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     param_bram_enb,
    output logic [PARAM_ADDR_W-1:0]  param_bram_addrb,
    input  logic [DATA_WIDTH-1:0]    param_bram_dout,
    output logic [W_NUM_OF_COLS-1:0] wbank_we,
    output logic [ROW_W-1:0]         wbank_addr,
    output logic [DATA_WIDTH-1:0]    wbank_din,
    output logic                     a_we,
    output logic [IDX_W-1:0]         a_idx,
    output logic [DATA_WIDTH-1:0]    a_din,
    output logic                     w_rdy_o,
    output logic                     a_rdy_o
);

    localparam int NW_L = W_NUM_OF_ROWS * W_NUM_OF_COLS;

    fetch_state_e            state_q;
    logic [PARAM_ADDR_W-1:0] addr_q;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    wrdy_q;
    logic                    ardy_q;

    logic       fetching;
    logic       issue;
    logic       wr_w;
    logic       wr_a;
    logic       last_w;
    logic       pipe_empty;
    fetch_tag_t tag_d;
    fetch_tag_t tag_out;

    assign fetching = (state_q == FETCH_W) || (state_q == FETCH_A);
    assign issue    = !rst_n && !stall_i && fetching;

    // Build the tag that travels alongside each read.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = issue;
        tag_d.is_a  = (state_q == FETCH_A);
        tag_d.col   = TAG_FW'(col_q);
        if (state_q == FETCH_A) begin
            tag_d.row_idx = TAG_FW'(idx_q);
        end else begin
            tag_d.row_idx = TAG_FW'(row_q);
        end
    end

    param_rd_pipe #(
        .LAT(BRAM_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .clr_i  (rst_n),
        .tag_i  (tag_d),
        .tag_o  (tag_out),
        .empty_o(pipe_empty)
    );

    assign wr_w   = !rst_n && tag_out.valid && !tag_out.is_a;
    assign wr_a   = !rst_n && tag_out.valid && tag_out.is_a;
    assign last_w = wr_w
                 && (tag_out.row_idx == TAG_FW'(W_NUM_OF_ROWS - 1))
                 && (tag_out.col == TAG_FW'(W_NUM_OF_COLS - 1));

    // Route the returning word to a W bank or the a register file.
    always_comb begin
        wbank_we   = '0;
        wbank_addr = '0;
        wbank_din  = '0;
        a_we       = 1'b0;
        a_idx      = '0;
        a_din      = '0;
        unique case (1'b1)
            wr_w: begin
                wbank_we   = W_NUM_OF_COLS'(1) << tag_out.col;
                wbank_addr = tag_out.row_idx[ROW_W-1:0];
                wbank_din  = param_bram_dout;
            end
            wr_a: begin
                a_we  = 1'b1;
                a_idx = tag_out.row_idx[IDX_W-1:0];
                a_din = param_bram_dout;
            end
            default: ;
        endcase
    end

    assign param_bram_enb   = issue;
    assign param_bram_addrb = issue ? addr_q : '0;

    // Fetch sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            ardy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (last_w) begin
                wrdy_q <= 1'b1;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= FETCH_W;
                        addr_q  <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        wrdy_q  <= 1'b0;
                        ardy_q  <= 1'b0;
                    end
                end
                FETCH_W: begin
                    if (!stall_i) begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == COL_W'(W_NUM_OF_COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (addr_q == PARAM_ADDR_W'(NW_L - 1)) begin
                            state_q <= FETCH_A;
                            idx_q   <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                        end
                    end
                end
                FETCH_A: begin
                    if (!stall_i) begin
                        addr_q <= addr_q + 1'b1;
                        idx_q  <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(A_DEPTH - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ardy_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign w_rdy_o = wrdy_q;
    assign a_rdy_o = ardy_q;

endmodule

// File: tb/tb_param_fetch_ctrl.sv
// Directed bench for param_fetch_ctrl with a cycle-level model.
// BRAM returns addr+100; scoreboard tracks every W/a element.
module tb_param_fetch_ctrl;

    localparam int R  = 4;
    localparam int C  = 3;
    localparam int A  = 6;
    localparam int L  = 2;
    localparam int NW = R * C;
    localparam int N  = NW + A;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          stall_i;
    logic          busy_o;
    logic          done_o;
    logic          param_bram_enb;
    logic [AW-1:0] param_bram_addrb;
    logic [15:0]   param_bram_dout;
    logic [C-1:0]  wbank_we;
    logic [1:0]    wbank_addr;
    logic [15:0]   wbank_din;
    logic          a_we;
    logic [2:0]    a_idx;
    logic [15:0]   a_din;
    logic          w_rdy_o;
    logic          a_rdy_o;

    param_fetch_ctrl #(
        .DATA_WIDTH   (16),
        .W_NUM_OF_ROWS(R),
        .W_NUM_OF_COLS(C),
        .A_DEPTH      (A),
        .BRAM_LAT     (L)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .param_bram_enb  (param_bram_enb),
        .param_bram_addrb(param_bram_addrb),
        .param_bram_dout (param_bram_dout),
        .wbank_we        (wbank_we),
        .wbank_addr      (wbank_addr),
        .wbank_din       (wbank_din),
        .a_we            (a_we),
        .a_idx           (a_idx),
        .a_din           (a_din),
        .w_rdy_o         (w_rdy_o),
        .a_rdy_o         (a_rdy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bram_q [L];

    always @(posedge clk) begin
        bram_q[0] <= param_bram_enb ?
                     16'(param_bram_addrb) + 16'd100 : 16'h0;
        for (int i = 1; i < L; i++) begin
            bram_q[i] <= bram_q[i-1];
        end
    end
    assign param_bram_dout = bram_q[L-1];

    int nerr;
    int nchk;
    int cur_tid;
    int cur_r;
    int gcyc;

    bit m_busy;
    bit m_wrdy;
    bit m_ardy;
    bit m_done;
    int m_next;
    int pend_addr [$];
    int pend_due  [$];

    int wcnt [R][C];
    int acnt [A];
    int n_wr;
    int n_done;
    int done_r;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s test%0d cyc%0d got=%0d exp=%0d",
                     nm, cur_tid, cur_r, got, exp);
        end
    endtask

    task automatic run_start();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) wcnt[i][j] = 0;
        for (int i = 0; i < A; i++) acnt[i] = 0;
        n_wr   = 0;
        n_done = 0;
        done_r = -1;
    endtask

    task automatic sb_final();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) chk("sb_wcnt", wcnt[i][j], 1);
        for (int i = 0; i < A; i++) chk("sb_acnt", acnt[i], 1);
        chk("sb_nwr", n_wr, N);
        chk("sb_ndone", n_done, 1);
    endtask

    task automatic do_cycle(input bit st, input bit sl, input bit rs,
                            input int tid, input int r);
        bit e_enb;
        bit e_wr;
        bit e_awe;
        bit old_busy;
        int e_addr;
        int e_we;
        cur_tid = tid;
        cur_r   = r;
        start_i = st;
        stall_i = sl;
        rst_n   = rs;
        #4;
        e_enb  = !rs && m_busy && (m_next < N) && !sl;
        e_wr   = !rs && (pend_due.size() > 0) && (pend_due[0] == gcyc);
        e_addr = e_wr ? pend_addr[0] : -1;
        e_we   = (e_wr && e_addr < NW) ? (1 << (e_addr % C)) : 0;
        e_awe  = e_wr && (e_addr >= NW);
        if (!(tid == 0 && r == 0)) begin
            chk("enb", param_bram_enb, e_enb);
            if (e_enb) chk("addrb", param_bram_addrb, m_next);
            chk("wbank_we", wbank_we, e_we);
            if (e_we != 0) begin
                chk("wbank_addr", wbank_addr, e_addr / C);
                chk("wbank_din", wbank_din, e_addr + 100);
            end
            chk("a_we", a_we, e_awe);
            if (e_awe) begin
                chk("a_idx", a_idx, e_addr - NW);
                chk("a_din", a_din, e_addr + 100);
            end
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            chk("w_rdy", w_rdy_o, m_wrdy);
            chk("a_rdy", a_rdy_o, m_ardy);
        end

        if (tid == 0 && r == 2) begin
            chk("rst_enb", param_bram_enb, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_wrdy", w_rdy_o, 0);
        end
        if (tid == 1 && r == 3) begin
            chk("t1_we0", wbank_we, 3'b001);
            chk("t1_row0", wbank_addr, 0);
            chk("t1_din0", wbank_din, 100);
        end
        if (tid == 1 && r == 14) begin
            chk("t1_we11", wbank_we, 3'b100);
            chk("t1_row11", wbank_addr, 3);
            chk("t1_din11", wbank_din, 111);
            chk("t1_wrdy_lo", w_rdy_o, 0);
        end
        if (tid == 1 && r == 15) chk("t1_wrdy_hi", w_rdy_o, 1);
        if (tid == 1 && r == 20) begin
            chk("t1_awe", a_we, 1);
            chk("t1_aidx", a_idx, 5);
            chk("t1_adin", a_din, 117);
            chk("t1_done_lo", done_o, 0);
        end
        if (tid == 1 && r == 21) begin
            chk("t1_done", done_o, 1);
            chk("t1_ardy", a_rdy_o, 1);
            chk("t1_busy", busy_o, 0);
        end
        if (tid == 5 && r == 0) chk("t5_ardy_hold", a_rdy_o, 1);
        if (tid == 5 && r == 1) begin
            chk("t5_wrdy_drop", w_rdy_o, 0);
            chk("t5_ardy_drop", a_rdy_o, 0);
            chk("t5_busy", busy_o, 1);
        end
        if (tid == 2 && r >= 5 && r <= 7) chk("t2_stall_enb", param_bram_enb, 0);
        if (tid == 2 && r == 8) chk("t2_addr_resume", param_bram_addrb, 4);
        if (tid == 4 && r == 11) begin
            chk("t4_enb", param_bram_enb, 0);
            chk("t4_busy", busy_o, 0);
            chk("t4_wrdy", w_rdy_o, 0);
            chk("t4_ardy", a_rdy_o, 0);
            chk("t4_done", done_o, 0);
        end
        if (tid == 4 && (r == 11 || r == 12)) begin
            chk("t4_no_wwr", wbank_we, 0);
            chk("t4_no_awr", a_we, 0);
        end

        for (int c = 0; c < C; c++) begin
            if (wbank_we[c] === 1'b1) begin
                n_wr++;
                wcnt[wbank_addr][c]++;
                chk("sb_wval", wbank_din, wbank_addr * C + c + 100);
            end
        end
        if (a_we === 1'b1) begin
            n_wr++;
            if (a_idx < A) acnt[a_idx]++;
            chk("sb_aval", a_din, NW + a_idx + 100);
        end
        if (done_o === 1'b1) begin
            n_done++;
            done_r = r;
        end

        if (rs) begin
            m_busy = 0;
            m_wrdy = 0;
            m_ardy = 0;
            m_done = 0;
            m_next = 0;
            pend_addr.delete();
            pend_due.delete();
        end else begin
            old_busy = m_busy;
            m_done   = 0;
            if (e_wr) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                if (e_addr == NW - 1) m_wrdy = 1;
                if (e_addr == N - 1) begin
                    m_done = 1;
                    m_ardy = 1;
                    m_busy = 0;
                end
            end
            if (e_enb) begin
                pend_addr.push_back(m_next);
                pend_due.push_back(gcyc + L);
                m_next++;
            end
            if (st && !old_busy) begin
                m_busy = 1;
                m_next = 0;
                m_wrdy = 0;
                m_ardy = 0;
            end
        end
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    initial begin
        nerr    = 0;
        nchk    = 0;
        gcyc    = 0;
        m_busy  = 0;
        m_wrdy  = 0;
        m_ardy  = 0;
        m_done  = 0;
        m_next  = 0;
        rst_n   = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) do_cycle(0, 0, 1, 0, r);

        run_start();
        for (int r = 0; r < 25; r++) do_cycle(r == 0, 0, 0, 1, r);
        sb_final();
        chk("t1_done_cyc", done_r, 21);

        run_start();
        for (int r = 0; r < 25; r++) do_cycle(r == 0, 0, 0, 5, r);
        sb_final();
        chk("t5_done_cyc", done_r, 21);

        run_start();
        for (int r = 0; r < 28; r++)
            do_cycle(r == 0, r >= 5 && r <= 7, 0, 2, r);
        sb_final();
        chk("t2_done_cyc", done_r, 24);

        run_start();
        for (int r = 0; r < 25; r++)
            do_cycle(r == 0 || r == 8, 0, 0, 3, r);
        sb_final();
        chk("t3_done_cyc", done_r, 21);

        run_start();
        for (int r = 0; r < 20; r++) do_cycle(r == 0, 0, r == 10, 4, r);
        chk("t4_ndone", n_done, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
